// File: rtl/apu_lp_pkg.sv
// apu_lp_pkg: shared state encoding and default sizes for the low-power Q-channel sequencer
package apu_lp_pkg;
  localparam int DEVICE_WIDTH_DEF = 3;
  localparam int IDLE_DELAY_WIDTH_DEF = 4;
  typedef enum logic [2:0] {
    ST_RUN,
    ST_REQ,
    ST_UNWIND_DENY,
    ST_UNWIND,
    ST_STOPPED,
    ST_WAKE
  } lp_state_e;
endpackage

// File: rtl/apu_lp_idle_timer.sv
// apu_lp_idle_timer: saturating idle counter compared against a live delay value
module apu_lp_idle_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [WIDTH-1:0] compare,
  output logic             expired
);
  logic [WIDTH-1:0] cnt;
  assign expired = cnt == compare;
  always_ff @(posedge clk)
    if (rst || clear) cnt <= '0;
    else if (!(&cnt)) cnt <= cnt + WIDTH'(1);
endmodule

// File: rtl/apu_lp_qch_sequencer.sv
// apu_lp_qch_sequencer: idle-driven Q-channel quiesce/wake sequencer with registered outputs
module apu_lp_qch_sequencer
  import apu_lp_pkg::*;
#(
  parameter int DEVICE_WIDTH = DEVICE_WIDTH_DEF,
  parameter int IDLE_DELAY_WIDTH = IDLE_DELAY_WIDTH_DEF
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_low_power_en,
  input  logic [IDLE_DELAY_WIDTH-1:0] i_low_power_idle_delay,
  input  logic                        i_wake_req,
  output logic [DEVICE_WIDTH-1:0]     o_devices_qreq_n,
  input  logic [DEVICE_WIDTH-1:0]     i_devices_qaccept_n,
  input  logic [DEVICE_WIDTH-1:0]     i_devices_qdeny,
  input  logic [DEVICE_WIDTH-1:0]     i_devices_qactive,
  output logic                        o_clk_en,
  output logic                        o_low_power_active,
  output logic                        o_deny_seen
);
  localparam int IW = DEVICE_WIDTH > 1 ? $clog2(DEVICE_WIDTH) : 1;
  localparam logic [IW-1:0] LAST = IW'(DEVICE_WIDTH - 1);
  lp_state_e state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic abort, abort_n, wake_cond, expired, deny, accept, first;
  logic [DEVICE_WIDTH-1:0] qreq_nx;
  assign wake_cond = i_wake_req | (|i_devices_qactive) | !i_low_power_en;
  assign deny = i_devices_qdeny[idx];
  assign accept = !i_devices_qaccept_n[idx];
  assign first = idx == '0;
  apu_lp_idle_timer #(.WIDTH(IDLE_DELAY_WIDTH)) u_timer (
    .clk(i_clk),
    .rst(i_rst),
    .clear(state != ST_RUN || wake_cond),
    .compare(i_low_power_idle_delay),
    .expired(expired)
  );
  always_comb begin
    state_n = state;
    idx_n = idx;
    abort_n = abort;
    case (state)
      ST_RUN: if (!wake_cond && expired) begin
        state_n = ST_REQ;
        idx_n = '0;
      end
      ST_REQ: begin
        abort_n = abort | wake_cond;
        if (deny) state_n = ST_UNWIND_DENY;
        else if (accept) begin
          state_n = abort ? ST_UNWIND : idx == LAST ? ST_STOPPED : ST_REQ;
          idx_n = abort || idx == LAST ? idx : idx + IW'(1);
        end
      end
      ST_UNWIND_DENY: if (!deny) begin
        state_n = first ? ST_RUN : ST_UNWIND;
        idx_n = first ? idx : idx - IW'(1);
      end
      ST_UNWIND, ST_WAKE: if (!accept) begin
        state_n = first ? ST_RUN : state;
        idx_n = first ? idx : idx - IW'(1);
      end
      ST_STOPPED: if (wake_cond) begin
        state_n = ST_WAKE;
        idx_n = LAST;
      end
      default: state_n = ST_RUN;
    endcase
    if (state_n == ST_RUN) abort_n = 1'b0;
    // devices below idx stay quiesced; REQ also holds the indexed device low
    qreq_nx = '1;
    for (int j = 0; j < DEVICE_WIDTH; j++)
      qreq_nx[j] = state_n == ST_STOPPED ? 1'b0 : state_n == ST_RUN ? 1'b1 :
                   state_n == ST_REQ ? IW'(j) > idx_n : IW'(j) >= idx_n;
  end
  always_ff @(posedge i_clk)
    if (i_rst) begin
      state <= ST_RUN;
      idx <= '0;
      abort <= 1'b0;
      o_devices_qreq_n <= '1;
      o_clk_en <= 1'b1;
      o_low_power_active <= 1'b0;
      o_deny_seen <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      abort <= abort_n;
      o_devices_qreq_n <= qreq_nx;
      o_clk_en <= state_n != ST_STOPPED;
      o_low_power_active <= state_n == ST_STOPPED;
      o_deny_seen <= o_deny_seen | (state == ST_REQ && deny);
    end
endmodule

// File: tb/tb_apu_lp_qch_sequencer.sv
// tb_apu_lp_qch_sequencer: randomized scenario bench with device responders and expected QREQn patterns
module tb_apu_lp_qch_sequencer;
  localparam int N = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b1;
  logic [3:0] delay = '0;
  logic wake = 1'b0;
  logic [N-1:0] qreq_n;
  logic [N-1:0] accept_n = '1;
  logic [N-1:0] deny = '0;
  logic [N-1:0] active = '0;
  logic clk_en, lp, deny_seen;
  int checks = 0;
  int failures = 0;

  apu_lp_qch_sequencer dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_low_power_en(en),
    .i_low_power_idle_delay(delay),
    .i_wake_req(wake),
    .o_devices_qreq_n(qreq_n),
    .i_devices_qaccept_n(accept_n),
    .i_devices_qdeny(deny),
    .i_devices_qactive(active),
    .o_clk_en(clk_en),
    .o_low_power_active(lp),
    .o_deny_seen(deny_seen)
  );

  always #5 clk = ~clk;

  // expected QREQn: devices below n are held low (quiesced), the rest high
  function automatic logic [N-1:0] low_below(int n);
    logic [N-1:0] r;
    for (int j = 0; j < N; j++) r[j] = j >= n;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = 1'b1;
    wake = 1'b0;
    active = '0;
    accept_n = '1;
    deny = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({qreq_n, clk_en, lp, deny_seen} !== {{N{1'b1}}, 3'b100}) begin
      failures++;
      $display("FAIL reset got=%b exp=%b", {qreq_n, clk_en, lp, deny_seen}, {{N{1'b1}}, 3'b100});
    end
  endtask

  task automatic test_entry(int d);
    do_reset();
    delay = 4'(d);
    for (int i = 0; i < d; i++) step();
    checks++;
    if (qreq_n !== '1) begin
      failures++;
      $display("FAIL entry_pre d=%0d got=%b exp=%b", d, qreq_n, {N{1'b1}});
    end
    step();
    checks++;
    if (qreq_n !== low_below(1)) begin
      failures++;
      $display("FAIL entry_req0 d=%0d got=%b exp=%b", d, qreq_n, low_below(1));
    end
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
        deny = N'($urandom) & low_below(k + 1);
        step();
        checks++;
        if (qreq_n !== low_below(k + 1)) begin
          failures++;
          $display("FAIL entry_hold k=%0d got=%b exp=%b", k, qreq_n, low_below(k + 1));
        end
      end
      deny = '0;
      accept_n[k] = 1'b0;
      step();
      if (k < N - 1) begin
        checks++;
        if (qreq_n !== low_below(k + 2) || clk_en !== 1'b1) begin
          failures++;
          $display("FAIL entry_advance k=%0d got=%b/%b exp=%b/1", k, qreq_n, clk_en, low_below(k + 2));
        end
      end else begin
        checks++;
        if ({qreq_n, clk_en, lp, deny_seen} !== {{N{1'b0}}, 3'b010}) begin
          failures++;
          $display("FAIL entry_stopped got=%b exp=%b", {qreq_n, clk_en, lp, deny_seen}, {{N{1'b0}}, 3'b010});
        end
      end
    end
  endtask

  task automatic test_wake(int d);
    for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
      step();
      checks++;
      if (lp !== 1'b1 || clk_en !== 1'b0) begin
        failures++;
        $display("FAIL wake_stay_stopped got=%b%b exp=01", clk_en, lp);
      end
    end
    active = N'(1) << $urandom_range(0, N - 1);
    step();
    active = '0;
    checks++;
    if ({clk_en, lp, qreq_n} !== {2'b10, low_below(N - 1)}) begin
      failures++;
      $display("FAIL wake_first got=%b exp=%b", {clk_en, lp, qreq_n}, {2'b10, low_below(N - 1)});
    end
    for (int k = N - 1; k >= 0; k--) begin
      for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
        step();
        checks++;
        if (qreq_n !== low_below(k) || clk_en !== 1'b1) begin
          failures++;
          $display("FAIL wake_hold k=%0d got=%b exp=%b", k, qreq_n, low_below(k));
        end
      end
      accept_n[k] = 1'b1;
      step();
      checks++;
      if (qreq_n !== low_below(k == 0 ? 0 : k - 1)) begin
        failures++;
        $display("FAIL wake_release k=%0d got=%b exp=%b", k, qreq_n, low_below(k == 0 ? 0 : k - 1));
      end
    end
    for (int i = 0; i < d; i++) step();
    checks++;
    if (qreq_n !== '1) begin
      failures++;
      $display("FAIL wake_run got=%b exp=%b", qreq_n, {N{1'b1}});
    end
    step();
    checks++;
    if (qreq_n !== low_below(1)) begin
      failures++;
      $display("FAIL wake_reentry got=%b exp=%b", qreq_n, low_below(1));
    end
  endtask

  task automatic test_abort(int a, int d);
    do_reset();
    delay = 4'(d);
    for (int i = 0; i <= d; i++) step();
    for (int k = 0; k < a; k++) begin
      accept_n[k] = 1'b0;
      step();
    end
    wake = 1'b1;
    step();
    wake = 1'b0;
    for (int i = 0; i <= int'($urandom_range(0, 3)); i++) begin
      checks++;
      if (qreq_n !== low_below(a + 1)) begin
        failures++;
        $display("FAIL abort_hold a=%0d got=%b exp=%b", a, qreq_n, low_below(a + 1));
      end
      step();
    end
    accept_n[a] = 1'b0;
    step();
    checks++;
    if ({lp, qreq_n} !== {1'b0, low_below(a)}) begin
      failures++;
      $display("FAIL abort_unwind a=%0d got=%b exp=%b", a, {lp, qreq_n}, {1'b0, low_below(a)});
    end
    for (int k = a; k >= 0; k--) begin
      accept_n[k] = 1'b1;
      step();
      checks++;
      if ({lp, qreq_n} !== {1'b0, low_below(k == 0 ? 0 : k - 1)}) begin
        failures++;
        $display("FAIL abort_release k=%0d got=%b exp=%b", k, {lp, qreq_n}, {1'b0, low_below(k == 0 ? 0 : k - 1)});
      end
    end
    for (int i = 0; i <= d; i++) step();
    for (int k = 0; k < N; k++) begin
      accept_n[k] = 1'b0;
      step();
    end
    checks++;
    if (lp !== 1'b1) begin
      failures++;
      $display("FAIL abort_cleared got=%b exp=1", lp);
    end
  endtask

  task automatic test_deny(int dv, bit both, int d);
    do_reset();
    delay = 4'(d);
    for (int i = 0; i <= d; i++) step();
    for (int k = 0; k < dv; k++) begin
      accept_n[k] = 1'b0;
      step();
    end
    deny[dv] = 1'b1;
    if (both) accept_n[dv] = 1'b0;
    for (int i = 0; i <= int'($urandom_range(0, 3)); i++) begin
      step();
      checks++;
      if ({deny_seen, lp, qreq_n} !== {2'b10, low_below(dv)}) begin
        failures++;
        $display("FAIL deny_release dv=%0d got=%b exp=%b", dv, {deny_seen, lp, qreq_n}, {2'b10, low_below(dv)});
      end
    end
    deny = '0;
    accept_n[dv] = 1'b1;
    step();
    checks++;
    if (qreq_n !== low_below(dv == 0 ? 0 : dv - 1)) begin
      failures++;
      $display("FAIL deny_cleared dv=%0d got=%b exp=%b", dv, qreq_n, low_below(dv == 0 ? 0 : dv - 1));
    end
    for (int k = dv - 1; k >= 0; k--) begin
      accept_n[k] = 1'b1;
      step();
      checks++;
      if (qreq_n !== low_below(k == 0 ? 0 : k - 1)) begin
        failures++;
        $display("FAIL deny_unwind k=%0d got=%b exp=%b", k, qreq_n, low_below(k == 0 ? 0 : k - 1));
      end
    end
    for (int i = 0; i < d; i++) step();
    checks++;
    if ({deny_seen, qreq_n} !== {1'b1, {N{1'b1}}}) begin
      failures++;
      $display("FAIL deny_run got=%b exp=%b", {deny_seen, qreq_n}, {1'b1, {N{1'b1}}});
    end
    step();
    checks++;
    if (qreq_n !== low_below(1)) begin
      failures++;
      $display("FAIL deny_reentry got=%b exp=%b", qreq_n, low_below(1));
    end
  endtask

  task automatic test_reset_stopped(int d);
    for (int k = 0; k < N; k++) begin
      accept_n[k] = 1'b0;
      step();
    end
    checks++;
    if ({lp, deny_seen} !== 2'b11) begin
      failures++;
      $display("FAIL rst_pre got=%b exp=11", {lp, deny_seen});
    end
    rst = 1'b1;
    step();
    checks++;
    if ({qreq_n, clk_en, lp, deny_seen} !== {{N{1'b1}}, 3'b100}) begin
      failures++;
      $display("FAIL rst_stopped got=%b exp=%b", {qreq_n, clk_en, lp, deny_seen}, {{N{1'b1}}, 3'b100});
    end
    rst = 1'b0;
    accept_n = '1;
    delay = 4'(d);
    for (int i = 0; i < d; i++) step();
    step();
    checks++;
    if (qreq_n !== low_below(1)) begin
      failures++;
      $display("FAIL rst_reentry got=%b exp=%b", qreq_n, low_below(1));
    end
  endtask

  task automatic test_enable_toggle();
    do_reset();
    delay = '0;
    for (int i = 0; i < int'($urandom_range(2, 6)); i++) begin
      en = 1'b0;
      step();
      checks++;
      if (qreq_n !== '1) begin
        failures++;
        $display("FAIL en_off got=%b exp=%b", qreq_n, {N{1'b1}});
      end
      en = 1'b1;
      if ($urandom_range(0, 1) == 1) begin
        wake = 1'b1;
        step();
        wake = 1'b0;
        checks++;
        if (qreq_n !== '1) begin
          failures++;
          $display("FAIL en_wake got=%b exp=%b", qreq_n, {N{1'b1}});
        end
      end
    end
    step();
    checks++;
    if (qreq_n !== low_below(1)) begin
      failures++;
      $display("FAIL en_on_delay0 got=%b exp=%b", qreq_n, low_below(1));
    end
  endtask

  task automatic test_delay_change();
    do_reset();
    delay = 4'd15;
    for (int i = 0; i < 5; i++) step();
    delay = 4'd8;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (qreq_n !== '1) begin
      failures++;
      $display("FAIL delay_change_pre got=%b exp=%b", qreq_n, {N{1'b1}});
    end
    step();
    checks++;
    if (qreq_n !== low_below(1)) begin
      failures++;
      $display("FAIL delay_change_hit got=%b exp=%b", qreq_n, low_below(1));
    end
  endtask

  task automatic test_saturate();
    do_reset();
    delay = 4'd15;
    for (int i = 0; i < 14; i++) step();
    delay = 4'd2;
    for (int i = 0; i < 30; i++) begin
      step();
      checks++;
      if (qreq_n !== '1) begin
        failures++;
        $display("FAIL saturate_nowrap cyc=%0d got=%b exp=%b", i, qreq_n, {N{1'b1}});
      end
    end
    delay = 4'd15;
    step();
    checks++;
    if (qreq_n !== low_below(1)) begin
      failures++;
      $display("FAIL saturate_hit15 got=%b exp=%b", qreq_n, low_below(1));
    end
  endtask

  initial begin
    int d;
    test_reset();
    test_entry(4);
    test_wake(4);
    for (int r = 0; r < 4; r++) begin
      d = int'($urandom_range(0, 15));
      test_entry(d);
      test_wake(d);
    end
    test_entry(0);
    test_wake(0);
    test_abort(0, 4);
    for (int r = 0; r < 3; r++) test_abort(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 6)));
    test_abort(N - 1, 2);
    test_deny(1, 1'b0, 4);
    test_reset_stopped(3);
    for (int r = 0; r < 3; r++) test_deny(int'($urandom_range(0, N - 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 6)));
    test_deny(0, 1'b1, 1);
    test_enable_toggle();
    test_delay_change();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/apu_lp_qch_sequencer.md
APU_LP_QCH_SEQUENCER -- requirements
Module: apu_lp_qch_sequencer

Interface
REQ-001 SHALL have parameter DEVICE_WIDTH, default 3: number of Q-channel devices, sequenced in index order.
REQ-002 SHALL have parameter IDLE_DELAY_WIDTH, default 4: width of the idle delay counter.
REQ-003 SHALL have i_clk, input, 1: single clock; all logic is posedge i_clk.
REQ-004 SHALL have i_rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have i_low_power_en, input, 1: CSR enable for low-power entry.
REQ-006 SHALL have i_low_power_idle_delay, input, IDLE_DELAY_WIDTH: idle cycles required before entry.
REQ-007 SHALL have i_wake_req, input, 1: external wake or abort request.
REQ-008 SHALL have o_devices_qreq_n, output, DEVICE_WIDTH: per-device QREQn.
REQ-009 SHALL have i_devices_qaccept_n, input, DEVICE_WIDTH: per-device QACCEPTn.
REQ-010 SHALL have i_devices_qdeny, input, DEVICE_WIDTH: per-device QDENY.
REQ-011 SHALL have i_devices_qactive, input, DEVICE_WIDTH: per-device QACTIVE.
REQ-012 SHALL have o_clk_en, output, 1: enable for the downstream clock gate.
REQ-013 SHALL have o_low_power_active, output, 1: high while the fabric is stopped.
REQ-014 SHALL have o_deny_seen, output, 1: sticky flag, set by any deny, cleared only by reset.

Function
REQ-015 SHALL implement the states RUN, REQ, UNWIND_DENY, UNWIND, STOPPED and WAKE, with a device index idx of width $clog2(DEVICE_WIDTH).
- Define wake_cond = i_wake_req | (|i_devices_qactive) | !i_low_power_en.
REQ-016 In RUN, the block SHALL set all qreq_n to 1 and o_clk_en to 1.
- The idle counter increments while !wake_cond and clears to 0 when wake_cond is high.
- When !wake_cond and counter == i_low_power_idle_delay, the block SHALL go to REQ with idx=0.
- A delay of 0 gives entry on the first idle cycle.
REQ-017 The counter SHALL saturate at its maximum value and never wrap.
REQ-018 In REQ, qreq_n[idx] SHALL be driven to 0, and qreq_n[j] for j<idx SHALL stay at 0.
REQ-019 In REQ, on qaccept_n[idx]==0 with no abort pending, the block SHALL increment idx, or go to STOPPED if idx==DEVICE_WIDTH-1.
REQ-020 In REQ, wake_cond SHALL set an abort-pending flag.
- qreq_n[idx] SHALL NOT rise before accept or deny, as the protocol requires.
- On accept with abort pending, the block SHALL go to UNWIND with the current idx.
REQ-021 In REQ, on qdeny[idx]==1, the block SHALL set o_deny_seen and go to UNWIND_DENY.
- If qdeny and an accept are seen in the same cycle, deny SHALL take priority.
REQ-022 In UNWIND_DENY, qreq_n[idx] SHALL be 1.
- On qdeny[idx]==0, the block SHALL go to UNWIND with idx-1, or to RUN if idx==0.
REQ-023 In UNWIND, qreq_n[idx] SHALL be 1.
- On qaccept_n[idx]==1, the block SHALL decrement idx, or go to RUN if idx==0.
- Exit from UNWIND is in reverse order only.
REQ-024 In STOPPED, the block SHALL drive o_clk_en=0 and o_low_power_active=1, with all qreq_n at 0.
- On wake_cond, the block SHALL go to WAKE with idx=DEVICE_WIDTH-1.
REQ-025 In WAKE, the block SHALL drive o_clk_en=1.
- qreq_n[idx] SHALL be 1 and qreq_n[j] for j<idx SHALL stay at 0.
- On qaccept_n[idx]==1, the block SHALL decrement idx, or go to RUN if idx==0.
REQ-026 Every entry to RUN SHALL clear the idle counter and the abort flag.
REQ-027 Outputs SHALL be registered, so o_clk_en falls exactly 1 cycle after the final accept is sampled.
- o_clk_en SHALL rise 1 cycle after wake_cond is sampled in STOPPED.
REQ-028 Changes on i_low_power_idle_delay SHALL take effect on the next compare, with no restart.
REQ-029 Deny or accept inputs on devices not currently indexed SHALL be ignored.

Reset
REQ-030 While i_rst=1, the block SHALL force state=RUN, idx=0, counter=0 and abort=0.
- While i_rst=1, the outputs SHALL be: all o_devices_qreq_n=1, o_clk_en=1, o_low_power_active=0, o_deny_seen=0.
REQ-031 A reset mid-handshake SHALL take effect at the next edge regardless of device state; connected devices share the reset domain.

Structure
REQ-032 The state enum typedef and the DEVICE_WIDTH and IDLE_DELAY_WIDTH defaults SHALL live in the shared package apu_lp_pkg.
REQ-033 The idle counter SHALL be a sub-module, apu_lp_idle_timer, with inputs clear and compare value and output expired.
REQ-034 The clock gate SHALL be external; the block SHALL drive only o_clk_en.

Verification
REQ-035 Delay=4 with all qactive=0: qreq_n[0] falls 5 cycles after idle; the devices accept in order 0,1,2; o_clk_en=0 and o_low_power_active=1 one cycle after accept[2].
REQ-036 Device 1 asserts qdeny: o_deny_seen=1; qreq_n[1] rises, then qreq_n[0] rises after qdeny[1] clears; return to RUN with counter=0.
REQ-037 In STOPPED, qactive[0] pulses for 1 cycle: o_clk_en=1 next cycle; qreq_n rises in order 2,1,0, each after the previous QACCEPTn rises; then RUN.
REQ-038 i_wake_req pulses while REQ waits on device 0: qreq_n[0] is held low until accept, then UNWIND, then RUN; STOPPED is never entered.
REQ-039 i_rst asserted in STOPPED: next cycle all qreq_n=1, o_clk_en=1, o_deny_seen=0, state=RUN.
REQ-040 Delay=0 with constant idle and i_low_power_en toggling every cycle: REQ is never entered while enable is 0; the counter saturates at 15 with delay=15 and no wrap.
